// File: rtl/rv32m_mdu_if.sv
// Request/response bundle between the EX stage and the RV32M multiply/divide unit.
interface rv32m_mdu_if #(
   parameter int unsigned XLEN = 32
) ();
   logic            start;
   logic [2:0]      func3;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (output start, func3, rs1, rs2, input busy, done, result);
   modport slave  (input start, func3, rs1, rs2, output busy, done, result);
endinterface

// File: rtl/rv32m_mdu.sv
// Iterative RV32M unit: shift-add multiply and restoring divide on operand magnitudes,
// one bit per cycle, with sign correction applied on the completing edge.
module rv32m_mdu #(
   parameter int unsigned XLEN = 32
) (
   input logic        clk,
   input logic        rst,
   rv32m_mdu_if.slave bus
);
   localparam int unsigned CW = $clog2(XLEN);
   localparam int unsigned AW = 2 * XLEN;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_d;
   logic [CW-1:0]   cnt;
   logic [AW-1:0]   acc, acc_step, acc_init, mul_p;
   logic [XLEN-1:0] opnd, opnd_init;
   logic [2:0]      op;
   logic            neg, neg_in;
   logic            busy, done;
   logic [XLEN-1:0] result;

   logic            a_signed, b_signed, a_neg, b_neg, is_div, special;
   logic            b_zero, ovf;
   logic [XLEN-1:0] a_mag, b_mag, special_res, div_v, final_res;
   logic [XLEN:0]   mul_sum, div_shift, div_diff;
   logic            load, last;

   // Decode the incoming request: magnitudes, result sign and the no-iteration cases.
   always_comb begin
      is_div   = bus.func3[2];
      a_signed = !(bus.func3 == 3'd3 || bus.func3 == 3'd5 || bus.func3 == 3'd7);
      b_signed = (bus.func3 == 3'd0 || bus.func3 == 3'd1 ||
                  bus.func3 == 3'd4 || bus.func3 == 3'd6);
      a_neg    = a_signed & bus.rs1[XLEN-1];
      b_neg    = b_signed & bus.rs2[XLEN-1];
      a_mag    = a_neg ? (XLEN'(0) - bus.rs1) : bus.rs1;
      b_mag    = b_neg ? (XLEN'(0) - bus.rs2) : bus.rs2;
      neg_in   = (is_div && bus.func3[1]) ? a_neg : (a_neg ^ b_neg);
      b_zero   = (bus.rs2 == '0);
      ovf      = !bus.func3[0] && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.rs2);
      special  = is_div && (b_zero || ovf);
      if (b_zero) special_res = bus.func3[1] ? bus.rs1 : '1;
      else        special_res = bus.func3[1] ? '0 : bus.rs1;
      acc_init  = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
      opnd_init = is_div ? b_mag : a_mag;
   end

   // One iteration of either datapath, plus the signed result it would produce.
   always_comb begin
      mul_sum   = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      div_shift = acc[AW-1:XLEN-1];
      div_diff  = div_shift - {1'b0, opnd};
      if (!op[2])              acc_step = {mul_sum, acc[XLEN-1:1]};
      else if (div_diff[XLEN]) acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else                     acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      mul_p = neg ? (AW'(0) - acc_step) : acc_step;
      div_v = op[1] ? acc_step[AW-1:XLEN] : acc_step[XLEN-1:0];
      if (op[2])              final_res = neg ? (XLEN'(0) - div_v) : div_v;
      else if (op[1:0] == '0) final_res = mul_p[XLEN-1:0];
      else                    final_res = mul_p[AW-1:XLEN];
   end

   // Next-state logic.
   always_comb begin
      state_d = state;
      load    = 1'b0;
      last    = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               load    = 1'b1;
               state_d = special ? DONE : RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (cnt == CW'(XLEN - 1)) begin
               last    = 1'b1;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         opnd   <= '0;
         op     <= '0;
         neg    <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         state <= state_d;
         busy  <= (state_d == RUN);
         done  <= (state_d == DONE);
         if (load) begin
            op   <= bus.func3;
            neg  <= neg_in;
            acc  <= acc_init;
            opnd <= opnd_init;
            cnt  <= '0;
            if (special) result <= special_res;
         end else if (state == RUN) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
            if (last) result <= final_res;
         end
      end
   end

   assign bus.busy   = busy;
   assign bus.done   = done;
   assign bus.result = result;
endmodule

// File: tb/tb_rv32m_mdu.sv
// Bench for rv32m_mdu: vector table plus hand-written control sequences, results
// checked through an expected-value queue.
module tb_rv32m_mdu;
   localparam int unsigned XLEN = 32;

   logic clk = 1'b0;
   logic rst;

   rv32m_mdu_if #(.XLEN(XLEN)) bus ();
   rv32m_mdu #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      bit          special;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          overlap  = 0;

   always @(negedge clk) if (bus.busy && bus.done) overlap++;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      int          ia, ib;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      ia = a;
      ib = b;
      p  = '0;
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(ia / ib);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(ia % ib);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
      if (!f3[2]) return 1'b0;
      if (b == 0) return 1'b1;
      return !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
   endfunction

   // Called at a falling edge: present a request and record its expected result.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
      bus.start = 1'b1;
      bus.func3 = f3;
      bus.rs1   = a;
      bus.rs2   = b;
      exp_q.push_back(exp);
   endtask

   // Waits for done (bounded), checks result, latency and busy length. poke>0 re-asserts
   // start with unrelated operands in that cycle after the request.
   task automatic wait_done(input string name, input bit special, input int poke);
      int          lat;
      int          bcnt;
      bit          seen;
      logic [31:0] want;
      @(negedge clk);
      lat  = 1;
      bcnt = 0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (lat == poke) begin
            bus.start = 1'b1;
            bus.func3 = 3'd4;
            bus.rs1   = 32'h1234_5678;
            bus.rs2   = 32'h0000_0003;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         if (bus.busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b0;
      if (!seen) begin
         chk({name, "_timeout"}, 32'd0, 32'd1);
         return;
      end
      if (exp_q.size() == 0) begin
         chk({name, "_no_expect"}, 32'd0, 32'd1);
         return;
      end
      want = exp_q.pop_front();
      chk(name, bus.result, want);
      chk({name, "_latency"}, 32'(lat), special ? 32'd1 : 32'd33);
      chk({name, "_busy_cycles"}, 32'(bcnt), special ? 32'd0 : 32'd32);
   endtask

   initial begin
      logic [2:0]  rf3;
      logic [31:0] ra, rb;

      vecs.push_back('{"mul_neg",      3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0});
      vecs.push_back('{"mulh_min",     3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0});
      vecs.push_back('{"mulhu_max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0});
      vecs.push_back('{"mulhsu_max",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0});
      vecs.push_back('{"div_neg7_2",   3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0});
      vecs.push_back('{"rem_neg7_2",   3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0});
      vecs.push_back('{"divu_neg7_2",  3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 1'b0});
      vecs.push_back('{"remu_neg7_2",  3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 1'b0});
      vecs.push_back('{"div_by0",      3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1});
      vecs.push_back('{"remu_by0",     3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b1});
      vecs.push_back('{"divu_by0",     3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1});
      vecs.push_back('{"rem_by0",      3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b1});
      vecs.push_back('{"div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
      vecs.push_back('{"rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
      vecs.push_back('{"divu_min_m1",  3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
      for (int i = 0; i < 8; i++) begin
         rf3 = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = (i == 7) ? 32'h0000_0000 : ((i == 6) ? 32'($urandom_range(1, 9)) : $urandom);
         vecs.push_back('{$sformatf("rand%0d_f%0d", i, rf3), rf3, ra, rb,
                          model(rf3, ra, rb), is_special(rf3, ra, rb)});
      end

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.func3 = 3'd0;
      bus.rs1   = '0;
      bus.rs2   = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy",   32'(bus.busy), 32'd0);
      chk("reset_done",   32'(bus.done), 32'd0);
      chk("reset_result", bus.result,    32'd0);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);
         wait_done(vecs[i].name, vecs[i].special, 0);
         @(negedge clk);
      end

      // Result holds in IDLE after completion.
      issue(3'd0, 32'd6, 32'd7, 32'd42);
      wait_done("mul_6_7", 1'b0, 0);
      repeat (2) @(negedge clk);
      chk("hold_result", bus.result, 32'd42);
      chk("hold_done",   32'(bus.done), 32'd0);

      // start with new operands mid-RUN is ignored.
      issue(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
      wait_done("start_mid_run", 1'b0, 5);
      @(negedge clk);
      chk("mid_run_no_restart", 32'(bus.busy), 32'd0);

      // Back-to-back: new request presented during the DONE cycle.
      issue(3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC);
      wait_done("b2b_first", 1'b0, 0);
      issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      wait_done("b2b_second", 1'b0, 0);
      issue(3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF);
      wait_done("b2b_special", 1'b1, 0);
      @(negedge clk);

      // Reset in the middle of RUN discards the operation.
      issue(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      chk("midrun_rst_busy",   32'(bus.busy), 32'd0);
      chk("midrun_rst_done",   32'(bus.done), 32'd0);
      chk("midrun_rst_result", bus.result,    32'd0);
      @(negedge clk);
      chk("midrun_rst_idle", 32'(bus.busy), 32'd0);
      issue(3'd0, 32'd3, 32'd4, 32'd12);
      wait_done("mul_after_rst", 1'b0, 0);
      @(negedge clk);

      chk("busy_done_overlap", 32'(overlap), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rv32m_mdu.md
# rv32m_mdu

Iterative RV32M multiply/divide unit in the EX stage, beside the ALU. It executes the M-extension operations selected by func3 whenever the decoder flags an M-type instruction (func7 = 0000001), using an IDLE/RUN/DONE state machine. It processes one bit per cycle and holds the pipeline through `busy` until it pulses `done` with a registered result.

## Interface
- `XLEN`, 32: operand/result width; RUN iteration count.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE or DONE.
- `func3` in 3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1` in XLEN: operand A (multiplicand/dividend).
- `rs2` in XLEN: operand B (multiplier/divisor).
- `busy` out 1: high while in RUN; hazard unit stalls on it.
- `done` out 1: one-cycle pulse in DONE; `result` valid.
- `result` out XLEN: registered; held until next completion or reset.

## Operation
- States: IDLE, RUN, DONE. Reset: state=IDLE, `busy`=0, `done`=0, `result`=0, counter=0.
- IDLE/DONE with `start`=1: latch func3 and operands, compute operand magnitudes and result sign, then go to RUN (counter=0), or go straight to DONE for a special case.
- IDLE/DONE with `start`=0: go to IDLE. DONE therefore lasts exactly one cycle.
- RUN: one iteration per edge. Counter runs 0..XLEN-1. On the edge where counter=XLEN-1, apply sign correction, write `result`, go to DONE.
- `start` in RUN is ignored; latched operands and func3 stay unchanged.
- Multiply: unsigned shift-add on magnitudes into a 2·XLEN accumulator. Negate the product if the sign flag is set.
  - Signedness per op: MUL/MULH signed×signed; MULHSU rs1 signed, rs2 unsigned; MULHU unsigned×unsigned.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide: restoring division on magnitudes, one quotient bit per iteration.
  - Quotient is negated if the operand signs differ (DIV only).
  - Remainder takes the sign of the dividend (REM only).
  - DIVU/REMU use no sign handling.
- Special cases (no RUN, `result` written on the start edge):
  - Divisor = 0: DIV/DIVU → all ones; REM/REMU → rs1.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- No exceptions or traps are raised for any operand values.

## Timing
- Start accepted at edge N:
  - Normal ops: `busy`=1 in cycles N+1..N+XLEN; `done`=1 in cycle N+XLEN+1. Latency is XLEN+1 cycles, i.e. 33 for XLEN=32.
  - Special cases: `done`=1 in cycle N+1; `busy` stays 0.
- `busy` and `done` are never high together.
- Back-to-back: `start` during the DONE cycle is accepted, so `done` and the new `busy` are in adjacent cycles with no IDLE gap.
- `result` changes only on the completing edge. It holds through IDLE and through the next RUN.
- `rst` in any state, including mid-RUN, wins over `start`: next cycle is IDLE with all outputs 0, and the partial result is discarded.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD (−3) → `done` exactly 33 cycles after start, `result`=0xFFFFFFEB, `busy` high 32 cycles.
- High-half products:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Division, rs1=0xFFFFFFF9 (−7), rs2=2:
  - DIV → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU → 0x7FFFFFFC; REMU → 1.
- Special cases, each with `done` one cycle after start and `busy` never high:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Control:
  - `start` with new operands mid-RUN → ignored, original result delivered.
  - `start` during DONE → new op runs immediately.
  - `rst` at RUN counter=10 → next cycle `busy`=0, `done`=0, `result`=0, state IDLE; a fresh MUL 3×4 then returns 12.
